pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 143 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer. It resets the PLL, waits for a synchronized lock and
// qualifies it for a stable window before it releases the downstream reset.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked_i,
    input  logic       clr_sticky_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] lock_loss_cnt_o,
    output logic       timeout_o
);

    localparam int MAX_A = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES;
    localparam int MAX_C = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
    localparam int TW    = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] PLL_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PLLRST,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_lkS;
    logic            w_timeoutEvt;
    logic            w_lossEvt;
    logic            r_pllRst;
    logic            r_sysRst;
    logic            r_ready;
    logic            r_lost;
    logic            r_timeout;
    logic [7:0]      r_cnt;

    assign w_lkS = r_sync2;

    always_comb begin
        w_next       = r_state;
        w_timeoutEvt = 1'b0;
        w_lossEvt    = 1'b0;
        case (r_state)
            PLLRST: begin
                if (r_timer == PLL_LAST) begin
                    w_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (w_lkS) begin
                    w_next = STABLE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_next       = PLLRST;
                    w_timeoutEvt = 1'b1;
                end
            end
            STABLE: begin
                if (!w_lkS) begin
                    w_next = WAIT_LOCK;
                end else if (r_timer == STABLE_LAST) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (!w_lkS) begin
                    w_next    = WAIT_LOCK;
                    w_lossEvt = 1'b1;
                end
            end
            default: w_next = PLLRST;
        endcase
    end

    // Outputs are registered from the next state, so they always equal a
    // decode of the state register without adding a cycle of latency.
    // The synchronizer is flushed while the PLL is held in reset so that a
    // lock indication from before the reset is never trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PLLRST;
            r_timer   <= '0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_pllRst  <= 1'b1;
            r_sysRst  <= 1'b1;
            r_ready   <= 1'b0;
            r_timeout <= 1'b0;
            r_lost    <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_state != RUN) begin
                r_timer <= r_timer + 1'b1;
            end

            if (r_state == PLLRST) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= pll_locked_i;
                r_sync2 <= r_sync1;
            end

            r_pllRst  <= (w_next == PLLRST);
            r_sysRst  <= (w_next != RUN);
            r_ready   <= (w_next == RUN);
            r_timeout <= w_timeoutEvt;

            if (w_lossEvt) begin
                r_lost <= 1'b1;
            end else if (clr_sticky_i) begin
                r_lost <= 1'b0;
            end

            if (w_lossEvt && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign pll_rst_o       = r_pllRst;
    assign sys_rst_o       = r_sysRst;
    assign ready_o         = r_ready;
    assign timeout_o       = r_timeout;
    assign lock_lost_o     = r_lost;
    assign lock_loss_cnt_o = r_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

    localparam int PLL_RST_CYCLES = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int NVEC           = 30;

    logic       clk;
    logic       rst;
    logic       pll_locked_i;
    logic       clr_sticky_i;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic       lock_lost_o;
    logic [7:0] lock_loss_cnt_o;
    logic       timeout_o;

    int testsRun;
    int testsFailed;
    int expCnt;

    typedef struct {
        logic       locked;
        logic       clr;
        logic       expPllRst;
        logic       expReady;
        logic       expLost;
        logic [7:0] expCnt;
    } vec_t;

    vec_t vecs [NVEC];

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked_i   (pll_locked_i),
        .clr_sticky_i   (clr_sticky_i),
        .pll_rst_o      (pll_rst_o),
        .sys_rst_o      (sys_rst_o),
        .ready_o        (ready_o),
        .lock_lost_o    (lock_lost_o),
        .lock_loss_cnt_o(lock_loss_cnt_o),
        .timeout_o      (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic locked, input logic clr);
        pll_locked_i = locked;
        clr_sticky_i = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " pll_rst"},  {7'd0, pll_rst_o},   8'd1);
        checkOutput({tag, " sys_rst"},  {7'd0, sys_rst_o},   8'd1);
        checkOutput({tag, " ready"},    {7'd0, ready_o},     8'd0);
        checkOutput({tag, " timeout"},  {7'd0, timeout_o},   8'd0);
        checkOutput({tag, " lost"},     {7'd0, lock_lost_o}, 8'd0);
        checkOutput({tag, " cnt"},      lock_loss_cnt_o,     8'd0);
    endtask

    task automatic waitReady(input int budget);
        int n;
        n = 0;
        while (!ready_o && n < budget) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkOutput("waitReady", {7'd0, ready_o}, 8'd1);
    endtask

    // Lock drops in RUN: two synchronizer cycles still show RUN, the third
    // edge must put the system back into reset.
    task automatic loseLock();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("loss pre ready", {7'd0, ready_o}, 8'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("loss sys_rst", {7'd0, sys_rst_o}, 8'd1);
        if (expCnt < 255) expCnt++;
        checkOutput("loss cnt", lock_loss_cnt_o, 8'(expCnt));
        waitReady(40);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        expCnt      = 0;

        // Bring-up with lock held, then a loss in RUN and relock (edge e = i+1).
        for (int i = 0; i < NVEC; i++) begin
            int e;
            e = i + 1;
            vecs[i].locked    = !(e >= 17 && e <= 19);
            vecs[i].clr       = 1'b0;
            vecs[i].expPllRst = (e < 4);
            vecs[i].expReady  = (e >= 15 && e <= 18) || (e >= 30);
            vecs[i].expLost   = (e >= 19);
            vecs[i].expCnt    = (e >= 19) ? 8'd1 : 8'd0;
        end

        rst          = 1'b1;
        pll_locked_i = 1'b1;
        clr_sticky_i = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0);
        checkResetState("reset");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].locked, vecs[i].clr);
            checkOutput($sformatf("vec%0d pll_rst", i + 1), {7'd0, pll_rst_o}, {7'd0, vecs[i].expPllRst});
            checkOutput($sformatf("vec%0d ready", i + 1),   {7'd0, ready_o},   {7'd0, vecs[i].expReady});
            checkOutput($sformatf("vec%0d sys_rst", i + 1), {7'd0, sys_rst_o}, {7'd0, !vecs[i].expReady});
            checkOutput($sformatf("vec%0d lost", i + 1),    {7'd0, lock_lost_o}, {7'd0, vecs[i].expLost});
            checkOutput($sformatf("vec%0d cnt", i + 1),     lock_loss_cnt_o,   vecs[i].expCnt);
            checkOutput($sformatf("vec%0d timeout", i + 1), {7'd0, timeout_o}, 8'd0);
        end

        // Isolated clear in RUN, then clear colliding with a new loss.
        applyStimulus(1'b1, 1'b1);
        checkOutput("clr in run lost", {7'd0, lock_lost_o}, 8'd0);
        checkOutput("clr in run cnt", lock_loss_cnt_o, 8'd1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("collision lost", {7'd0, lock_lost_o}, 8'd1);
        checkOutput("collision cnt", lock_loss_cnt_o, 8'd2);
        checkOutput("collision sys_rst", {7'd0, sys_rst_o}, 8'd1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("late clr lost", {7'd0, lock_lost_o}, 8'd0);
        checkOutput("late clr cnt", lock_loss_cnt_o, 8'd2);
        waitReady(40);

        // Fresh start, three losses, then a one-cycle reset from RUN.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        waitReady(40);
        expCnt = 0;
        repeat (3) loseLock();
        checkOutput("pre-reset cnt", lock_loss_cnt_o, 8'd3);
        checkOutput("pre-reset lost", {7'd0, lock_lost_o}, 8'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkResetState("mid reset");
        rst = 1'b0;

        // No lock ever: retry every 4+32 cycles.
        for (int i = 1; i <= 80; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("to%0d timeout", i), {7'd0, timeout_o},
                        {7'd0, (i == 36 || i == 72)});
            checkOutput($sformatf("to%0d pll_rst", i), {7'd0, pll_rst_o},
                        {7'd0, (i <= 3) || (i >= 36 && i <= 39) || (i >= 72 && i <= 75)});
            checkOutput($sformatf("to%0d sys_rst", i), {7'd0, sys_rst_o}, 8'd1);
        end

        // One-cycle glitch sampled as the stable count reaches 5.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(i != 12, 1'b0);
            checkOutput($sformatf("gl%0d ready", i), {7'd0, ready_o}, {7'd0, (i >= 23)});
        end
        checkOutput("glitch lost", {7'd0, lock_lost_o}, 8'd0);
        checkOutput("glitch cnt", lock_loss_cnt_o, 8'd0);

        // Counter saturation over 300 losses.
        expCnt = 0;
        for (int k = 1; k <= 300; k++) begin
            loseLock();
        end
        checkOutput("sat cnt", lock_loss_cnt_o, 8'd255);
        checkOutput("sat lost", {7'd0, lock_lost_o}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
